// File: rtl/axis_stream_checker.sv
// AXI-Stream sink/checker: expected beats are queued in a FIFO from a second stream,
// DUT beats are accepted under programmable backpressure and compared under tkeep.
module axis_stream_checker #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned EXP_DEPTH  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     exp_tdata,
    input  logic                      exp_tlast,
    input  logic                      exp_tvalid,
    output logic                      exp_tready,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      cfg_enable,
    input  logic [1:0]                cfg_mode,
    input  logic [7:0]                cfg_stall,
    input  logic                      cfg_clear,
    output logic [31:0]               word_count,
    output logic [31:0]               pkt_count,
    output logic                      err_data,
    output logic                      err_last,
    output logic [31:0]               first_err_idx,
    output logic                      pkt_done
);
    localparam int unsigned KeepW  = DATA_WIDTH / 8;
    localparam int unsigned AddrW  = $clog2(EXP_DEPTH);
    localparam int unsigned EntryW = DATA_WIDTH + 1;
    localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

    logic [EntryW-1:0] mem_q [EXP_DEPTH];
    logic [AddrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              fifo_full, fifo_empty, push, hs;
    logic [EntryW-1:0] head;
    logic              head_last;
    logic [DATA_WIDTH-1:0] head_data;

    logic              gate_q, gate_d;
    logic [7:0]        stall_cnt_q, stall_cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic [31:0]       word_count_q, word_count_d, pkt_count_q, pkt_count_d;
    logic [31:0]       first_err_idx_q, first_err_idx_d;
    logic              err_data_q, err_data_d, err_last_q, err_last_d;
    logic              pkt_done_q, pkt_done_d;
    logic              data_mis, last_mis;
    logic [31:0]       wc_base, pc_base;
    logic              ed_base, el_base;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                        (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign exp_tready    = rst_n & ~fifo_full;
    assign s_axis_tready = cfg_enable & gate_q & ~fifo_empty;
    assign push = exp_tvalid & exp_tready;
    assign hs   = s_axis_tvalid & s_axis_tready;
    assign head = mem_q[rd_ptr_q[AddrW-1:0]];
    assign head_last = head[EntryW-1];
    assign head_data = head[DATA_WIDTH-1:0];

    // Pointer advance; a full FIFO blocks the push even when a pop frees a slot this cycle.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = hs ? rd_ptr_q + PtrOne : rd_ptr_q;
    end

    // Storage array is left unreset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= {exp_tlast, exp_tdata};
        end
    end

    // Backpressure gate: free-running LFSR and a mode-1 stall counter.
    always_comb begin
        gate_d      = 1'b1;
        stall_cnt_d = stall_cnt_q;
        lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        case (cfg_mode)
            2'd1: begin
                gate_d      = (stall_cnt_q == 8'd0);
                stall_cnt_d = (stall_cnt_q >= cfg_stall) ? 8'd0 : stall_cnt_q + 8'd1;
            end
            2'd2:    gate_d = (lfsr_q[7:0] >= cfg_stall);
            default: gate_d = 1'b1;
        endcase
    end

    // Byte-wise masked compare of the FIFO head against the offered DUT beat.
    always_comb begin
        data_mis = 1'b0;
        for (int i = 0; i < KeepW; i++) begin
            if (s_axis_tkeep[i] && (head_data[8*i +: 8] != s_axis_tdata[8*i +: 8])) begin
                data_mis = 1'b1;
            end
        end
        last_mis = (head_last != s_axis_tlast);
    end

    // Status next state: clear applies first, then a coincident handshake is accounted.
    always_comb begin
        wc_base = cfg_clear ? 32'd0 : word_count_q;
        pc_base = cfg_clear ? 32'd0 : pkt_count_q;
        ed_base = cfg_clear ? 1'b0 : err_data_q;
        el_base = cfg_clear ? 1'b0 : err_last_q;
        word_count_d    = wc_base;
        pkt_count_d     = pc_base;
        err_data_d      = ed_base;
        err_last_d      = el_base;
        first_err_idx_d = cfg_clear ? 32'd0 : first_err_idx_q;
        pkt_done_d      = hs & s_axis_tlast;
        if (hs) begin
            word_count_d = (wc_base == 32'hFFFF_FFFF) ? wc_base : wc_base + 32'd1;
            if (s_axis_tlast) begin
                pkt_count_d = (pc_base == 32'hFFFF_FFFF) ? pc_base : pc_base + 32'd1;
            end
            err_data_d = ed_base | data_mis;
            err_last_d = el_base | last_mis;
            if ((data_mis || last_mis) && !(ed_base || el_base)) begin
                first_err_idx_d = wc_base;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            gate_q          <= 1'b0;
            stall_cnt_q     <= 8'd0;
            lfsr_q          <= LFSR_SEED;
            word_count_q    <= 32'd0;
            pkt_count_q     <= 32'd0;
            err_data_q      <= 1'b0;
            err_last_q      <= 1'b0;
            first_err_idx_q <= 32'd0;
            pkt_done_q      <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            gate_q          <= gate_d;
            stall_cnt_q     <= stall_cnt_d;
            lfsr_q          <= lfsr_d;
            word_count_q    <= word_count_d;
            pkt_count_q     <= pkt_count_d;
            err_data_q      <= err_data_d;
            err_last_q      <= err_last_d;
            first_err_idx_q <= first_err_idx_d;
            pkt_done_q      <= pkt_done_d;
        end
    end

    assign word_count    = word_count_q;
    assign pkt_count     = pkt_count_q;
    assign err_data      = err_data_q;
    assign err_last      = err_last_q;
    assign first_err_idx = first_err_idx_q;
    assign pkt_done      = pkt_done_q;
endmodule

// File: tb/tb_axis_stream_checker.sv
// Bench for axis_stream_checker: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axis_stream_checker;
    localparam int unsigned DW = 128;
    localparam int unsigned KW = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [DW-1:0] exp_tdata, s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic exp_tlast, exp_tvalid, exp_tready;
    logic s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic cfg_enable, cfg_clear;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_stall;
    logic [31:0] word_count, pkt_count, first_err_idx;
    logic err_data, err_last, pkt_done;

    always #5 clk = ~clk;

    axis_stream_checker #(.DATA_WIDTH(DW), .EXP_DEPTH(DEPTH), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n),
        .exp_tdata(exp_tdata), .exp_tlast(exp_tlast), .exp_tvalid(exp_tvalid),
        .exp_tready(exp_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_stall(cfg_stall),
        .cfg_clear(cfg_clear),
        .word_count(word_count), .pkt_count(pkt_count), .err_data(err_data),
        .err_last(err_last), .first_err_idx(first_err_idx), .pkt_done(pkt_done)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW:0]  mq[$];
    bit           m_gate, m_ed, m_el, m_done;
    int unsigned  m_phase;
    logic [15:0]  m_lfsr = 16'hACE1;
    logic [31:0]  m_wc, m_pc, m_idx;

    always @(posedge clk) begin : model
        logic [DW:0] head;
        bit hs, push, dmis, lmis;
        if (!rst_n) begin
            mq.delete();
            m_gate = 0; m_phase = 0; m_lfsr = 16'hACE1;
            m_wc = 0; m_pc = 0; m_idx = 0; m_ed = 0; m_el = 0; m_done = 0;
        end else begin
            hs   = s_axis_tvalid && cfg_enable && m_gate && (mq.size() != 0);
            push = exp_tvalid && (mq.size() < DEPTH);
            m_done = hs && s_axis_tlast;
            if (cfg_clear) begin
                m_wc = 0; m_pc = 0; m_ed = 0; m_el = 0; m_idx = 0;
            end
            if (hs) begin
                head = mq.pop_front();
                dmis = 0;
                for (int b = 0; b < KW; b++)
                    if (s_axis_tkeep[b] && head[8*b +: 8] != s_axis_tdata[8*b +: 8]) dmis = 1;
                lmis = (head[DW] != s_axis_tlast);
                if ((dmis || lmis) && !(m_ed || m_el)) m_idx = m_wc;
                m_ed = m_ed | dmis;
                m_el = m_el | lmis;
                m_wc = m_wc + 1;
                if (s_axis_tlast) m_pc = m_pc + 1;
            end
            if (push) mq.push_back({exp_tlast, exp_tdata});
            case (cfg_mode)
                2'd1: begin
                    m_gate  = (m_phase == 0);
                    m_phase = (m_phase >= cfg_stall) ? 0 : m_phase + 1;
                end
                2'd2:    m_gate = (m_lfsr[7:0] >= cfg_stall);
                default: m_gate = 1;
            endcase
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("exp_tready", 32'(exp_tready), 32'(rst_n && (mq.size() < DEPTH)));
        chk("s_axis_tready", 32'(s_axis_tready),
            32'(rst_n && cfg_enable && m_gate && (mq.size() != 0)));
        chk("word_count", word_count, m_wc);
        chk("pkt_count", pkt_count, m_pc);
        chk("err_data", 32'(err_data), 32'(m_ed));
        chk("err_last", 32'(err_last), 32'(m_el));
        chk("first_err_idx", first_err_idx, m_idx);
        chk("pkt_done", 32'(pkt_done), 32'(m_done));
    end

    int unsigned done_cnt = 0;
    always @(negedge clk) if (pkt_done) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    bit nxt_clr = 0;
    logic [DW-1:0] bd[4096];
    bit            bl[4096];
    int unsigned   exp_i, dut_i;

    // One cycle: sample readiness for the coming edge, then drive inputs.
    task automatic cyc(input bit ev, input logic [DW-1:0] ed, input bit el,
                       input bit sv, input logic [DW-1:0] sd, input logic [KW-1:0] sk,
                       input bit sl, output bit e_hs, output bit s_hs);
        bit er, sr;
        @(negedge clk);
        er = exp_tready;
        sr = s_axis_tready;
        #1;
        exp_tvalid = ev; exp_tdata = ed; exp_tlast = el;
        s_axis_tvalid = sv; s_axis_tdata = sd; s_axis_tkeep = sk; s_axis_tlast = sl;
        cfg_clear = nxt_clr;
        nxt_clr = 0;
        e_hs = ev && er;
        s_hs = sv && sr;
    endtask

    task automatic idle(input int n);
        bit e, s;
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, '0, '0, 0, e, s);
    endtask

    task automatic send_exp(input logic [DW-1:0] d, input bit l);
        bit e, s;
        int n = 0;
        do begin
            cyc(1, d, l, 0, '0, '0, 0, e, s);
            n++;
        end while (!e && n < 100);
        if (!e) chk("exp_push_timeout", 32'(e), 32'd1);
    endtask

    task automatic send_dut(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit l);
        bit e, s;
        int n = 0;
        do begin
            cyc(0, '0, 0, 1, d, k, l, e, s);
            n++;
        end while (!s && n < 300);
        if (!s) chk("dut_beat_timeout", 32'(s), 32'd1);
    endtask

    task automatic do_reset();
        idle(1);
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        exp_i = 0;
        dut_i = 0;
    endtask

    task automatic rand_run(input int ncyc, input int pe, input int pd, input int pcor,
                            input int pclr, input int pen);
        bit e, s, ev, sv, sl;
        logic [DW-1:0] sd;
        logic [KW-1:0] sk;
        int r;
        for (int i = 0; i < ncyc; i++) begin
            ev = ($urandom % 100) < pe;
            sv = ($urandom % 100) < pd;
            sd = bd[dut_i % 4096];
            sl = bl[dut_i % 4096];
            if (($urandom % 100) < pcor) sd = sd ^ (128'hFF << (8 * ($urandom % 16)));
            if (pcor != 0 && ($urandom % 100) < 5) sl = !sl;
            r = $urandom % 10;
            sk = (r < 7) ? '1 : (r < 9) ? KW'($urandom) : '0;
            if (($urandom % 1000) < pclr) nxt_clr = 1;
            cyc(ev, bd[exp_i % 4096], bl[exp_i % 4096], sv, sd, sk, sl, e, s);
            if (e) exp_i++;
            if (s) dut_i++;
            if (pen != 0 && ($urandom % 100) < 3) cfg_enable = !cfg_enable;
        end
        cfg_enable = 1;
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        bit e, s;
        int cycles, got;
        int unsigned d0;
        exp_tvalid = 0; exp_tdata = '0; exp_tlast = 0;
        s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
        cfg_enable = 1; cfg_mode = 2'd0; cfg_stall = 8'd0; cfg_clear = 0;
        for (int i = 0; i < 4096; i++) begin
            bd[i] = {$urandom, $urandom, $urandom, $urandom};
            bl[i] = ($urandom % 4) == 0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("reset_exp_tready", 32'(exp_tready), 32'd0);
        chk("reset_s_tready", 32'(s_axis_tready), 32'd0);
        chk("reset_word_count", word_count, 32'd0);
        rst_n = 1;

        // Mode 0: four clean beats, one packet.
        for (int b = 1; b <= 4; b++) send_exp(DW'(b), b == 4);
        d0 = done_cnt;
        for (int b = 1; b <= 4; b++) send_dut(DW'(b), '1, b == 4);
        idle(2);
        chk("t1_word_count", word_count, 32'd4);
        chk("t1_pkt_count", pkt_count, 32'd1);
        chk("t1_pkt_done_pulses", done_cnt - d0, 32'd1);
        chk("t1_err_data", 32'(err_data), 32'd0);
        chk("t1_err_last", 32'(err_last), 32'd0);

        // Byte 0 differs: masked, then unmasked.
        for (int pass = 0; pass < 2; pass++) begin
            nxt_clr = 1;
            idle(1);
            for (int b = 0; b < 4; b++) send_exp(DW'(16 + b), b == 3);
            for (int b = 0; b < 4; b++)
                send_dut((b == 2) ? DW'(16 + b) ^ DW'(8'h5A) : DW'(16 + b),
                         (pass == 0) ? 16'hFFFE : 16'hFFFF, b == 3);
            idle(1);
            if (pass == 0) begin
                chk("t2_masked_err_data", 32'(err_data), 32'd0);
                chk("t2_masked_word_count", word_count, 32'd4);
            end else begin
                chk("t2_unmasked_err_data", 32'(err_data), 32'd1);
                chk("t2_first_err_idx", first_err_idx, 32'd2);
            end
        end

        // Early tlast, then a later data error leaves the index alone.
        nxt_clr = 1;
        idle(1);
        for (int b = 0; b < 3; b++) send_exp(DW'(32 + b), b == 2);
        send_dut(DW'(32), '1, 0);
        send_dut(DW'(33), '1, 1);
        send_dut(DW'(34) ^ DW'(16'hFF00), '1, 1);
        idle(1);
        chk("t3_err_last", 32'(err_last), 32'd1);
        chk("t3_err_data", 32'(err_data), 32'd1);
        chk("t3_first_err_idx", first_err_idx, 32'd1);
        chk("t3_pkt_count", pkt_count, 32'd2);

        // Mode 1, stall 3: one ready cycle in four.
        nxt_clr = 1;
        cfg_mode = 2'd1;
        cfg_stall = 8'd3;
        idle(1);
        for (int b = 0; b < 8; b++) send_exp(DW'(48 + b), b == 7);
        cycles = 0;
        got = 0;
        while (got < 8 && cycles < 100) begin
            cyc(0, '0, 0, 1, DW'(48 + got), '1, got == 7, e, s);
            cycles++;
            if (s) got++;
        end
        idle(1);
        chk("t4_cycles_29_to_32", 32'(cycles >= 29 && cycles <= 32), 32'd1);
        chk("t4_word_count", word_count, 32'd8);
        chk("t4_err_data", 32'(err_data), 32'd0);

        // Full FIFO, simultaneous pop/push, pointer wrap.
        cfg_mode = 2'd0;
        nxt_clr = 1;
        idle(1);
        for (int b = 0; b < DEPTH; b++) send_exp(DW'(64 + b), b == DEPTH - 1);
        idle(1);
        chk("t5_full_exp_tready", 32'(exp_tready), 32'd0);
        cyc(1, DW'(80), 1, 1, DW'(64), '1, 0, e, s);
        chk("t5_push_blocked_when_full", 32'(e), 32'd0);
        chk("t5_pop_when_full", 32'(s), 32'd1);
        cyc(1, DW'(80), 1, 0, '0, '0, 0, e, s);
        chk("t5_push_next_cycle", 32'(e), 32'd1);
        for (int b = 1; b < DEPTH; b++) send_dut(DW'(64 + b), '1, b == DEPTH - 1);
        send_dut(DW'(80), '1, 1);
        exp_i = 0;
        dut_i = 0;
        rand_run(300, 70, 70, 0, 0, 0);
        cycles = 0;
        while (dut_i < exp_i && cycles < 500) begin
            rand_run(1, 0, 100, 0, 0, 0);
            cycles++;
        end
        idle(1);
        chk("t5_wrap_beats", 32'(exp_i >= 3 * DEPTH), 32'd1);
        chk("t5_wrap_word_count", word_count, 32'(DEPTH + 1) + 32'(exp_i));
        chk("t5_wrap_err_data", 32'(err_data), 32'd0);
        chk("t5_wrap_err_last", 32'(err_last), 32'd0);

        // Reset mid-packet with the FIFO half full.
        for (int b = 0; b < DEPTH / 2; b++) send_exp(DW'(96 + b), 0);
        send_dut(DW'(96), '1, 0);
        send_dut(DW'(97), '1, 0);
        idle(1);
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("t6_rst_exp_tready", 32'(exp_tready), 32'd0);
        chk("t6_rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("t6_rst_word_count", word_count, 32'd0);
        rst_n = 1;
        idle(2);
        chk("t6_empty_s_tready", 32'(s_axis_tready), 32'd0);
        chk("t6_exp_tready", 32'(exp_tready), 32'd1);

        // Clear coincident with an erroring handshake.
        for (int b = 0; b < 4; b++) send_exp(DW'(112 + b), 0);
        send_dut(DW'(112), '1, 0);
        send_dut(DW'(113), '1, 0);
        send_dut(DW'(114) ^ DW'(1), '1, 0);
        idle(1);
        chk("t6_pre_idx", first_err_idx, 32'd2);
        nxt_clr = 1;
        cyc(0, '0, 0, 1, DW'(115) ^ DW'(16'h0100), '1, 0, e, s);
        chk("t6_clear_hs", 32'(s), 32'd1);
        idle(1);
        chk("t6_clear_word_count", word_count, 32'd1);
        chk("t6_clear_err_data", 32'(err_data), 32'd1);
        chk("t6_clear_first_err_idx", first_err_idx, 32'd0);

        // Randomized traffic across modes, with clears, enable toggles and mode changes.
        do_reset();
        cfg_mode = 2'd0;
        rand_run(600, 60, 70, 5, 10, 1);
        cfg_mode = 2'd1;
        cfg_stall = 8'($urandom_range(0, 5));
        rand_run(600, 60, 80, 5, 10, 1);
        cfg_mode = 2'd2;
        cfg_stall = 8'($urandom_range(0, 200));
        rand_run(600, 60, 80, 5, 10, 1);
        cfg_mode = 2'd3;
        rand_run(400, 50, 60, 5, 10, 1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
